// File: rtl/loader_pkg.sv
// Shared state encodings, frame geometry and small helpers for the instruction loader.
package loader_pkg;

    localparam int HDR_LEN        = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef logic [2:0]             state_t;
    typedef logic [8*HDR_LEN-1:0]   word_count_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LEN_LO = 3'd1;
    localparam state_t ST_LEN_HI = 3'd2;
    localparam state_t ST_DATA   = 3'd3;
    localparam state_t ST_WRITE  = 3'd4;
    localparam state_t ST_CHECK  = 3'd5;
    localparam state_t ST_DONE   = 3'd6;
    localparam state_t ST_ERROR  = 3'd7;

    // States that consume a byte from the stream.
    function automatic logic state_accepts_bytes(input state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHECK);
    endfunction

    // States from which a start pulse launches a new load.
    function automatic logic state_can_start(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream handshake plus instruction-memory write port seen by the loader.
interface instruction_loader_if;

    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [63:0] mem_address;
    logic [63:0] mem_data;
    logic        mem_E;
    logic        mem_RW;

    // master = the loader, slave = stream source and memory
    modport master (
        input  byte_in, byte_valid,
        output byte_ready, mem_address, mem_data, mem_E, mem_RW
    );

    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, mem_address, mem_data, mem_E, mem_RW
    );

endinterface

// File: rtl/word_assembler.sv
// Packs accepted bytes LSB-first into 32-bit words and keeps a running XOR of them.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_complete,
    output logic [7:0]  xor_acc
);

    localparam int LANE_W = $clog2(BYTES_PER_WORD);

    logic [31:0]       shift_reg;
    logic [LANE_W-1:0] lane_reg;
    logic [7:0]        xor_reg;

    // The completed word is presented combinationally so it can be captured on the lane-3 edge.
    assign word          = {byte_in, shift_reg[31:8]};
    assign word_complete = accept && (lane_reg == LANE_W'(BYTES_PER_WORD - 1));
    assign xor_acc       = xor_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            shift_reg <= '0;
            lane_reg  <= '0;
            xor_reg   <= '0;
        end else if (accept) begin
            shift_reg <= word;
            lane_reg  <= lane_reg + 1'b1;
            xor_reg   <= xor_reg ^ byte_in;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Boot-time loader: parses a length-prefixed, XOR-checked byte frame and writes
// one 32-bit instruction per memory word while holding the CPU.
module instruction_loader
    import loader_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'd0,
    parameter logic [63:0] ADDR_STEP = 64'd4,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    instruction_loader_if.master    bus,
    output logic                    cpu_hold,
    output logic                    done,
    output logic                    error,
    output logic [15:0]             words_written
);

    state_t      state_reg, state_next;
    logic [7:0]  len_lo_reg;
    word_count_t len_reg;
    word_count_t ww_reg;
    logic [63:0] mem_address_reg;
    logic [63:0] mem_data_reg;

    logic        transfer;
    logic        clear;
    logic        asm_accept;
    logic [31:0] asm_word;
    logic        asm_complete;
    logic [7:0]  asm_xor;
    word_count_t len_value;
    logic        last_word;

    assign bus.byte_ready = state_accepts_bytes(state_reg);
    assign transfer       = bus.byte_valid && bus.byte_ready;
    assign clear          = start && state_can_start(state_reg);
    assign asm_accept     = transfer && (state_reg == ST_DATA);
    assign len_value      = {bus.byte_in, len_lo_reg};
    assign last_word      = ({1'b0, ww_reg} + 17'd1) == {1'b0, len_reg};

    word_assembler u_word_assembler (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .accept        (asm_accept),
        .byte_in       (bus.byte_in),
        .word          (asm_word),
        .word_complete (asm_complete),
        .xor_acc       (asm_xor)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_LEN_LO;
            ST_LEN_LO: if (transfer) state_next = ST_LEN_HI;
            ST_LEN_HI: begin
                if (transfer) begin
                    if (len_value == '0 || 32'(len_value) > MAX_WORDS)
                        state_next = ST_ERROR;
                    else
                        state_next = ST_DATA;
                end
            end
            ST_DATA:   if (asm_complete) state_next = ST_WRITE;
            ST_WRITE:  state_next = last_word ? ST_CHECK : ST_DATA;
            ST_CHECK: begin
                if (transfer)
                    state_next = (bus.byte_in == asm_xor) ? ST_DONE : ST_ERROR;
            end
            ST_DONE, ST_ERROR: if (start) state_next = ST_LEN_LO;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            len_lo_reg      <= '0;
            len_reg         <= '0;
            ww_reg          <= '0;
            mem_address_reg <= '0;
            mem_data_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (clear)
                ww_reg <= '0;
            else if (state_reg == ST_WRITE)
                ww_reg <= ww_reg + 1'b1;
            if (transfer && state_reg == ST_LEN_LO)
                len_lo_reg <= bus.byte_in;
            if (transfer && state_reg == ST_LEN_HI)
                len_reg <= len_value;
            // Capture address and data on the lane-3 edge so both are stable for the whole WRITE cycle.
            if (asm_complete) begin
                mem_address_reg <= BASE_ADDR + 64'(ww_reg) * ADDR_STEP;
                mem_data_reg    <= {32'h0, asm_word};
            end
        end
    end

    assign bus.mem_E       = (state_reg == ST_WRITE);
    assign bus.mem_RW      = (state_reg == ST_WRITE);
    assign bus.mem_address = mem_address_reg;
    assign bus.mem_data    = mem_data_reg;

    assign done          = (state_reg == ST_DONE);
    assign error         = (state_reg == ST_ERROR);
    assign cpu_hold      = (state_reg != ST_DONE);
    assign words_written = ww_reg;

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized frame-level bench for instruction_loader against a frame-parsing reference model.
module tb_instruction_loader;

    localparam int MAX_W = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cpu_hold, done, error;
    logic [15:0] words_written;

    instruction_loader_if bus();

    instruction_loader #(
        .BASE_ADDR (64'd0),
        .ADDR_STEP (64'd4),
        .MAX_WORDS (MAX_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .bus           (bus),
        .cpu_hold      (cpu_hold),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int viol  = 0;

    logic [7:0]  frame[$];
    logic [31:0] wq[$];
    logic [63:0] got_addr[$], got_data[$];
    logic [63:0] exp_addr[$], exp_data[$];
    logic        exp_done, exp_err;
    int          exp_ww;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor and bus-rule watcher.
    always @(negedge clk) begin
        if (rst_n && bus.mem_E) begin
            got_addr.push_back(bus.mem_address);
            got_data.push_back(bus.mem_data);
            $display("[TB] write addr=0x%0h data=0x%0h", bus.mem_address, bus.mem_data);
        end
        if (bus.mem_E && bus.byte_ready) viol++;
        if (bus.mem_RW !== bus.mem_E) viol++;
    end

    // Reference: parse the frame by its definition and derive writes and final status.
    task automatic model();
        int n;
        logic [7:0]  x;
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        n = int'(frame[0]) + 256 * int'(frame[1]);
        if (n == 0 || n > MAX_W) begin
            exp_done = 1'b0; exp_err = 1'b1; exp_ww = 0;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = 32'(int'(frame[2+4*i])) + 32'(int'(frame[3+4*i])) * 32'd256
              + 32'(int'(frame[4+4*i])) * 32'd65536 + 32'(int'(frame[5+4*i])) * 32'd16777216;
            exp_addr.push_back(64'(i) * 64'd4);
            exp_data.push_back(64'(w));
            for (int k = 0; k < 4; k++) x = x ^ frame[2+4*i+k];
        end
        exp_ww   = n;
        exp_done = (frame[2+4*n] == x);
        exp_err  = !exp_done;
    endtask

    // Builds LEN, the words in wq, and the checksum XOR-ed with chk_flip.
    task automatic make_frame(input logic [7:0] chk_flip);
        logic [7:0] c;
        int n;
        n = wq.size();
        frame.delete();
        frame.push_back(8'(n));
        frame.push_back(8'(n / 256));
        c = 8'h00;
        foreach (wq[i]) begin
            for (int k = 0; k < 4; k++) begin
                frame.push_back(8'(wq[i] >> (8*k)));
                c = c ^ 8'(wq[i] >> (8*k));
            end
        end
        frame.push_back(c ^ chk_flip);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Entered and left at a negedge; gap is the percent chance of an idle cycle before the byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        while (gap > 0 && $urandom_range(99) < gap && n < 8) begin
            bus.byte_valid = 1'b0;
            bus.byte_in    = 8'($urandom_range(255));
            @(negedge clk);
            n++;
        end
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        n = 0;
        while (!bus.byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic compare_writes(input string tag);
        check_eq({tag, "_nwrites"}, 64'(got_addr.size()), 64'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check_eq({tag, "_addr"}, got_addr[i], exp_addr[i]);
            check_eq({tag, "_data"}, got_data[i], exp_data[i]);
        end
    endtask

    task automatic run_frame(input string tag, input int gap);
        int n;
        model();
        got_addr.delete();
        got_data.delete();
        pulse_start();
        check_eq({tag, "_hold_after_start"}, 64'(cpu_hold), 64'd1);
        check_eq({tag, "_ww_cleared"}, 64'(words_written), 64'd0);
        check_eq({tag, "_flags_cleared"}, 64'({done, error}), 64'd0);
        foreach (frame[i]) send_byte(frame[i], gap);
        bus.byte_valid = 1'b0;
        n = 0;
        while (!(done || error) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq({tag, "_finish_timeout"}, 64'd0, 64'd1);
        compare_writes(tag);
        check_eq({tag, "_ww"}, 64'(words_written), 64'(exp_ww));
        check_eq({tag, "_done"}, 64'(done), 64'(exp_done));
        check_eq({tag, "_error"}, 64'(error), 64'(exp_err));
        check_eq({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(!exp_done));
        $display("[TB] frame %s bytes=%0d writes=%0d done=%0b error=%0b",
                 tag, frame.size(), got_addr.size(), done, error);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 64'(bus.byte_ready), 64'd0);
        check_eq({tag, "_memE"}, 64'({bus.mem_E, bus.mem_RW}), 64'd0);
        check_eq({tag, "_addr"}, bus.mem_address, 64'd0);
        check_eq({tag, "_data"}, bus.mem_data, 64'd0);
        check_eq({tag, "_flags"}, 64'({done, error}), 64'd0);
        check_eq({tag, "_hold"}, 64'(cpu_hold), 64'd1);
        check_eq({tag, "_ww"}, 64'(words_written), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Two-instruction image, no gaps.
        wq = {32'h00500093, 32'h00A00113};
        make_frame(8'h00);
        run_frame("two_words", 0);

        // Zero-length and oversized headers.
        frame = {8'h00, 8'h00};
        run_frame("len_zero", 0);
        frame = {8'h01, 8'h01};
        run_frame("len_257", 0);

        // Single word with a corrupted checksum.
        wq = {32'h12345678};
        make_frame(8'h01);
        run_frame("bad_chk", 0);

        // Same two-word image with ~50% valid duty.
        wq = {32'h00500093, 32'h00A00113};
        make_frame(8'h00);
        run_frame("two_words_gaps", 50);

        // Randomized frames, some with broken checksums.
        for (int f = 0; f < 8; f++) begin
            wq.delete();
            for (int i = 0; i < int'($urandom_range(1, 5)); i++) wq.push_back($urandom);
            make_frame(($urandom_range(3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
            run_frame($sformatf("rand%0d", f), 40);
        end

        // Largest accepted image.
        wq.delete();
        for (int i = 0; i < MAX_W; i++) wq.push_back($urandom);
        make_frame(8'h00);
        run_frame("max_words", 0);

        // Mid-frame start is ignored, then reset aborts the load.
        wq = {32'hCAFEF00D, 32'h0BADBEEF};
        make_frame(8'h00);
        got_addr.delete();
        got_data.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(frame[i], 0);
        bus.byte_valid = 1'b0;
        pulse_start();
        for (int i = 4; i < 7; i++) send_byte(frame[i], 0);
        bus.byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("midstart_nwrites", 64'(got_addr.size()), 64'd1);
        if (got_addr.size() > 0) begin
            check_eq("midstart_addr", got_addr[0], 64'd0);
            check_eq("midstart_data", got_data[0], 64'hCAFEF00D);
        end
        check_eq("midstart_ww", 64'(words_written), 64'd1);
        check_eq("midstart_flags", 64'({done, error}), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        @(negedge clk);
        run_frame("after_reset", 30);

        check_eq("memE_rules", 64'(viol), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
Boot-time writer for the 64-bit instruction memory. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit RISC-V instructions. Each instruction is written to consecutive word addresses through the memory's dataIn/E/RW/address port. The processor is held (cpu_hold) until a complete, checksum-verified image has been written.

Parameters:
BASE_ADDR, 0, byte address of the first instruction written
ADDR_STEP, 4, address increment per instruction
MAX_WORDS, 256, largest accepted instruction count

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous, active-low reset
start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in valid this cycle
byte_ready  output  1  loader accepts byte_in this cycle (transfer = valid & ready)
mem_address  output  64  instruction memory address
mem_data  output  64  write data, instruction zero-extended to 64 bits
mem_E  output  1  memory enable, one-cycle pulse per write
mem_RW  output  1  1 = write; high only together with mem_E
cpu_hold  output  1  keeps the CPU PC from advancing; low only in DONE
done  output  1  image loaded and verified (level)
error  output  1  load aborted (level)
words_written  output  16  count of instruction words written this load

Behaviour:
- Reset (rst_n low at clk edge): state IDLE. byte_ready=0, mem_E=0, mem_RW=0, mem_address=0, mem_data=0, done=0, error=0, cpu_hold=1, words_written=0.
- Frame format: LEN_LO, LEN_HI (N, 16-bit little-endian), then 4*N instruction bytes (LSB first), then CHK.
- CHK is the XOR of every byte after LEN_HI.
- States:
  - IDLE: start -> LEN_LO. Clears words_written, done, error and the XOR accumulator.
  - LEN_LO: after one transfer -> LEN_HI.
  - LEN_HI: after one transfer, if N==0 or N>MAX_WORDS -> ERROR; else -> DATA.
  - DATA: accepts bytes into the byte-lane counter (0..3). The transfer on lane 3 -> WRITE.
  - WRITE: lasts exactly one cycle.
    - byte_ready=0.
    - mem_E=1, mem_RW=1.
    - mem_address = BASE_ADDR + words_written*ADDR_STEP.
    - mem_data = {32'b0, assembled word}.
    - words_written increments at the end of the cycle.
    - Next state: CHECK if words_written+1==N, else DATA.
  - CHECK: after one transfer, byte==accumulator -> DONE, else -> ERROR.
  - DONE: done=1, cpu_hold=0.
  - ERROR: error=1, cpu_hold=1.
  - start in DONE or ERROR -> LEN_LO with all counters cleared. cpu_hold returns to 1 the cycle after start.
- byte_ready=1 only in LEN_LO, LEN_HI, DATA and CHECK; it is a function of state only, never of byte_valid.
- Latency: lane-3 transfer at edge t -> write strobe during cycle t+1. Peak throughput is one instruction per 5 cycles.
- byte_valid gaps are allowed anywhere. State and lane counter hold while there is no transfer.
- start while in LEN_LO..CHECK is ignored.
- mem_address/mem_data hold their last value when mem_E=0.
- Address arithmetic is 64-bit unsigned; no wrap within MAX_WORDS.
- Reset mid-load: returns to IDLE next edge with cpu_hold=1. Memory words already written are not cleared.

Decomposition:
- Shared package (loader_pkg): state enum (IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR) and frame-field constants (header length 2, bytes per word 4).
- Sub-module word_assembler: 2-bit lane counter, 32-bit shift register (new byte into bits [31:24] after shifting right by 8), and XOR accumulator. Inputs: clear and byte-accept strobe. Outputs: word and word_complete.

Test Plan:
1. Load N=2: words 0x00500093, 0x00A00113, CHK=XOR of the 8 bytes.
   -> exactly two write strobes: addr 0 data 0x00500093, then addr 4 data 0x00A00113.
   -> words_written=2, done=1, cpu_hold=0.
2. Header N=0 (bytes 00 00) -> ERROR after LEN_HI, no mem_E pulse, error=1, cpu_hold=1.
3. Header N=257 with MAX_WORDS=256 -> ERROR, no writes.
4. Valid 1-word frame with CHK wrong by 0x01 -> one write at addr 0, then error=1, done=0, cpu_hold=1.
5. Random byte_valid gaps (~50% duty) on frame 1 -> identical write sequence and final status.
   -> mem_E never high while byte_ready is high.
6. rst_n low after 5 data bytes -> IDLE with all outputs at reset values.
   -> a subsequent start and a full frame write from address 0 again.
   -> a start pulse mid-frame has no effect.
